// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the rPLL dynamic-mode controller.
package pll_ctrl_pkg;

    localparam int CODE_W    = 6;
    localparam int MAX_MODES = 16;
    localparam int TAB_W     = CODE_W * MAX_MODES;

    typedef enum logic [2:0] {
        ST_APPLY,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } pll_state_e;

    // Tables are zero-extended to TAB_W by the caller so one signature fits any N_MODES.
    function automatic logic [CODE_W-1:0] tab_entry(input logic [TAB_W-1:0] tab,
                                                     input logic [3:0]       idx);
        return tab[32'(idx) * CODE_W +: CODE_W];
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous rPLL LOCK into the sys_clk domain.
module pll_lock_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic pll_lock,
    output logic lock_s
);

    logic lock_meta;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

endmodule

// File: rtl/pll_dyn_mode_ctrl.sv
// Run-time divider-preset sequencer for a Gowin rPLL; optional auto-retry via PLL_AUTO_RETRY_EN.
//  state     | meaning
//  APPLY     | pll_reset held, divider codes loaded from the cur_mode preset
//  WAIT_LOCK | PLL released, waiting for synced lock within the timeout
//  STABLE    | lock seen, counting consecutive locked cycles
//  RUN       | lock qualified, pixel domain out of reset
//  FAIL      | lock timeout, PLL held in reset until a new request
module pll_dyn_mode_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int                       N_MODES      = 4,
    parameter int                       MODE_W       = 2,
    parameter logic [6*N_MODES-1:0]     IDSEL_TAB    = '0,
    parameter logic [6*N_MODES-1:0]     FBDSEL_TAB   = '0,
    parameter logic [6*N_MODES-1:0]     ODSEL_TAB    = '0,
    parameter int                       RST_CYCLES   = 16,
    parameter int                       LOCK_TIMEOUT = 2700000,
    parameter int                       LOCK_STABLE  = 1024,
    parameter int                       MAX_RETRY    = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [MODE_W-1:0] mode_sel,
    input  logic              mode_req,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [5:0]        idsel,
    output logic [5:0]        fbdsel,
    output logic [5:0]        odsel,
    output logic              pix_rst,
    output logic              locked,
    output logic              busy,
    output logic [MODE_W-1:0] cur_mode,
    output logic              err_timeout,
    output logic              err_badmode
);

`ifdef PLL_AUTO_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int ST_W  = $clog2(LOCK_STABLE + 1);
    localparam int RT_W  = $clog2(MAX_RETRY + 1);

    localparam logic [TAB_W-1:0] ID_EXT = TAB_W'(IDSEL_TAB);
    localparam logic [TAB_W-1:0] FB_EXT = TAB_W'(FBDSEL_TAB);
    localparam logic [TAB_W-1:0] OD_EXT = TAB_W'(ODSEL_TAB);

    pll_state_e        state_q, state_d;
    logic [RST_W-1:0]  cnt_rst_q, cnt_rst_d;
    logic [TO_W-1:0]   cnt_to_q, cnt_to_d;
    logic [ST_W-1:0]   cnt_st_q, cnt_st_d;
    logic [RT_W-1:0]   retry_q, retry_d;
    logic [MODE_W-1:0] cur_mode_d;
    logic [5:0]        idsel_d, fbdsel_d, odsel_d;
    logic              pll_reset_d, pix_rst_d, locked_d, busy_d, err_timeout_d, err_badmode_d;
    logic              lock_s, mode_ok, accept, run_entry;

    pll_lock_sync u_lock_sync (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .pll_lock (pll_lock),
        .lock_s   (lock_s)
    );

    assign mode_ok = 32'(mode_sel) < 32'(N_MODES);
    assign accept  = mode_req && mode_ok && (state_q == ST_RUN || state_q == ST_FAIL);

    always_comb begin
        state_d       = state_q;
        cnt_rst_d     = cnt_rst_q;
        cnt_to_d      = cnt_to_q;
        cnt_st_d      = cnt_st_q;
        retry_d       = retry_q;
        cur_mode_d    = cur_mode;
        idsel_d       = idsel;
        fbdsel_d      = fbdsel;
        odsel_d       = odsel;
        pll_reset_d   = pll_reset;
        pix_rst_d     = pix_rst;
        locked_d      = locked;
        busy_d        = busy;
        err_timeout_d = err_timeout;
        err_badmode_d = mode_req && !mode_ok;
        run_entry     = 1'b0;

        case (state_q)
            ST_APPLY: begin
                if (cnt_rst_q == '0) begin
                    idsel_d  = tab_entry(ID_EXT, 4'(cur_mode));
                    fbdsel_d = tab_entry(FB_EXT, 4'(cur_mode));
                    odsel_d  = tab_entry(OD_EXT, 4'(cur_mode));
                end
                if (cnt_rst_q == RST_W'(RST_CYCLES - 1)) begin
                    state_d     = ST_WAIT_LOCK;
                    cnt_rst_d   = '0;
                    cnt_to_d    = '0;
                    pll_reset_d = 1'b0;
                end else begin
                    cnt_rst_d = cnt_rst_q + RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    if (LOCK_STABLE <= 1) begin
                        run_entry = 1'b1;
                    end else begin
                        state_d  = ST_STABLE;
                        cnt_st_d = ST_W'(1);
                    end
                end else if (cnt_to_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                    if (RETRY_EN && retry_q < RT_W'(MAX_RETRY)) begin
                        retry_d     = retry_q + RT_W'(1);
                        state_d     = ST_APPLY;
                        cnt_rst_d   = '0;
                        pll_reset_d = 1'b1;
                    end else begin
                        state_d       = ST_FAIL;
                        pll_reset_d   = 1'b1;
                        busy_d        = 1'b0;
                        err_timeout_d = 1'b1;
                    end
                end else begin
                    cnt_to_d = cnt_to_q + TO_W'(1);
                end
            end
            ST_STABLE: begin
                // Timeout counter is held here so a flaky lock cannot extend the overall budget.
                if (!lock_s) begin
                    state_d  = ST_WAIT_LOCK;
                    cnt_st_d = '0;
                end else if (cnt_st_q == ST_W'(LOCK_STABLE - 1)) begin
                    run_entry = 1'b1;
                end else begin
                    cnt_st_d = cnt_st_q + ST_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d   = ST_WAIT_LOCK;
                    locked_d  = 1'b0;
                    pix_rst_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_to_d  = '0;
                end
            end
            ST_FAIL: begin
            end
            default: state_d = ST_APPLY;
        endcase

        if (run_entry) begin
            state_d   = ST_RUN;
            locked_d  = 1'b1;
            busy_d    = 1'b0;
            pix_rst_d = 1'b0;
            retry_d   = '0;
            cnt_st_d  = '0;
        end

        if (accept) begin
            state_d       = ST_APPLY;
            cur_mode_d    = mode_sel;
            cnt_rst_d     = '0;
            cnt_to_d      = '0;
            cnt_st_d      = '0;
            retry_d       = '0;
            pll_reset_d   = 1'b1;
            pix_rst_d     = 1'b1;
            locked_d      = 1'b0;
            busy_d        = 1'b1;
            err_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_APPLY;
            cnt_rst_q   <= '0;
            cnt_to_q    <= '0;
            cnt_st_q    <= '0;
            retry_q     <= '0;
            cur_mode    <= '0;
            idsel       <= tab_entry(ID_EXT, 4'd0);
            fbdsel      <= tab_entry(FB_EXT, 4'd0);
            odsel       <= tab_entry(OD_EXT, 4'd0);
            pll_reset   <= 1'b1;
            pix_rst     <= 1'b1;
            locked      <= 1'b0;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            err_badmode <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_rst_q   <= cnt_rst_d;
            cnt_to_q    <= cnt_to_d;
            cnt_st_q    <= cnt_st_d;
            retry_q     <= retry_d;
            cur_mode    <= cur_mode_d;
            idsel       <= idsel_d;
            fbdsel      <= fbdsel_d;
            odsel       <= odsel_d;
            pll_reset   <= pll_reset_d;
            pix_rst     <= pix_rst_d;
            locked      <= locked_d;
            busy        <= busy_d;
            err_timeout <= err_timeout_d;
            err_badmode <= err_badmode_d;
        end
    end

endmodule

// File: tb/tb_pll_dyn_mode_ctrl.sv
// Directed bench for pll_dyn_mode_ctrl; define PLL_AUTO_RETRY_EN to exercise the retry path.
module tb_pll_dyn_mode_ctrl;

    localparam int N_MODES = 3;
    localparam int MODE_W  = 2;

    localparam logic [5:0] ID0 = 6'h05, ID1 = 6'h11, ID2 = 6'h22;
    localparam logic [5:0] FB0 = 6'h0c, FB1 = 6'h1b, FB2 = 6'h2a;
    localparam logic [5:0] OD0 = 6'h16, OD1 = 6'h27, OD2 = 6'h38;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic [MODE_W-1:0] mode_sel = '0;
    logic              mode_req = 1'b0;
    logic              pll_lock = 1'b0;
    logic              pll_reset, pix_rst, locked, busy, err_timeout, err_badmode;
    logic [5:0]        idsel, fbdsel, odsel;
    logic [MODE_W-1:0] cur_mode;

    int total = 0;
    int bad   = 0;

    pll_dyn_mode_ctrl #(
        .N_MODES      (N_MODES),
        .MODE_W       (MODE_W),
        .IDSEL_TAB    ({ID2, ID1, ID0}),
        .FBDSEL_TAB   ({FB2, FB1, FB0}),
        .ODSEL_TAB    ({OD2, OD1, OD0}),
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100),
        .LOCK_STABLE  (8),
        .MAX_RETRY    (3)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .mode_sel    (mode_sel),
        .mode_req    (mode_req),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .idsel       (idsel),
        .fbdsel      (fbdsel),
        .odsel       (odsel),
        .pix_rst     (pix_rst),
        .locked      (locked),
        .busy        (busy),
        .cur_mode    (cur_mode),
        .err_timeout (err_timeout),
        .err_badmode (err_badmode)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fail_at;
        int rises;
        int exp_fail;
        int exp_rises;
        logic prev_rst;

        // 1: reset values, power-up sequence to RUN on entry 0
        tick(2);
        check("rst_pll_reset", pll_reset, 1);
        check("rst_pix_rst", pix_rst, 1);
        check("rst_locked", locked, 0);
        check("rst_busy", busy, 1);
        check("rst_cur_mode", cur_mode, 0);
        check("rst_codes", {idsel, fbdsel, odsel}, {ID0, FB0, OD0});
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_badmode", err_badmode, 0);
        sys_rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("apply_pulse", pll_reset, (i < 4) ? 1 : 0);
        end
        check("codes_entry0", {idsel, fbdsel, odsel}, {ID0, FB0, OD0});
        pll_lock = 1'b1;
        tick(9);
        check("lock_pending", locked, 0);
        check("lock_pending_busy", busy, 1);
        tick();
        check("run_locked", locked, 1);
        check("run_pix_rst", pix_rst, 0);
        check("run_busy", busy, 0);

        // 2: switch to mode 2
        mode_sel = 2'd2;
        mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        check("req2_cur_mode", cur_mode, 2);
        check("req2_pix_rst", pix_rst, 1);
        check("req2_locked", locked, 0);
        check("req2_busy", busy, 1);
        check("req2_pll_reset", pll_reset, 1);
        tick();
        check("req2_codes", {idsel, fbdsel, odsel}, {ID2, FB2, OD2});
        check("req2_codes_in_reset", pll_reset, 1);
        tick(2);
        check("req2_pulse_end", pll_reset, 1);
        tick();
        check("req2_release", pll_reset, 0);
        tick(7);
        check("req2_relock_pending", locked, 0);
        tick();
        check("req2_relock", locked, 1);

        // 3: lock lost for good, timeout (with retries when enabled) into FAIL
        pll_lock = 1'b0;
        tick(2);
        check("loss_still_locked", locked, 1);
        tick();
        check("loss_locked", locked, 0);
        check("loss_pix_rst", pix_rst, 1);
        check("loss_no_pll_reset", pll_reset, 0);
        check("loss_busy", busy, 1);
        fail_at  = 0;
        rises    = 0;
        prev_rst = pll_reset;
        for (int i = 4; i <= 600; i++) begin
            tick();
            if (pll_reset && !prev_rst && !err_timeout) rises++;
            prev_rst = pll_reset;
            if (err_timeout) begin
                fail_at = i;
                break;
            end
        end
`ifdef PLL_AUTO_RETRY_EN
        exp_fail  = 415;
        exp_rises = 3;
`else
        exp_fail  = 103;
        exp_rises = 0;
`endif
        check("fail_cycle", fail_at, exp_fail);
        check("retry_pulses", rises, exp_rises);
        check("fail_pll_reset", pll_reset, 1);
        check("fail_pix_rst", pix_rst, 1);
        check("fail_locked", locked, 0);
        check("fail_busy", busy, 0);
        tick(3);
        check("fail_sticky", err_timeout, 1);
        mode_sel = 2'd1;
        mode_req = 1'b1;
        pll_lock = 1'b1;
        tick();
        mode_req = 1'b0;
        check("fail_exit_err", err_timeout, 0);
        check("fail_exit_busy", busy, 1);
        check("fail_exit_mode", cur_mode, 1);
        tick();
        check("mode1_codes", {idsel, fbdsel, odsel}, {ID1, FB1, OD1});
        tick(10);
        check("mode1_pending", locked, 0);
        tick();
        check("mode1_locked", locked, 1);

        // 4: invalid mode, then a request dropped while busy
        mode_sel = 2'd3;
        mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        check("bad_pulse", err_badmode, 1);
        check("bad_cur_mode", cur_mode, 1);
        check("bad_locked", locked, 1);
        check("bad_busy", busy, 0);
        tick();
        check("bad_pulse_end", err_badmode, 0);
        check("bad_still_locked", locked, 1);
        mode_sel = 2'd0;
        mode_req = 1'b1;
        tick();
        check("req0_cur_mode", cur_mode, 0);
        mode_sel = 2'd2;
        tick();
        mode_req = 1'b0;
        check("busy_req_dropped", cur_mode, 0);
        check("busy_req_busy", busy, 1);
        tick(10);
        check("req0_pending", locked, 0);
        tick();
        check("req0_locked", locked, 1);
        check("req0_final_mode", cur_mode, 0);
        check("req0_codes", {idsel, fbdsel, odsel}, {ID0, FB0, OD0});

        // 5: one-cycle lock glitch in RUN, second glitch at stable count 5
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick(2);
        check("glitch_locked", locked, 0);
        check("glitch_pix_rst", pix_rst, 1);
        check("glitch_no_pll_reset", pll_reset, 0);
        check("glitch_busy", busy, 1);
        tick(3);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        check("glitch2_locked", locked, 0);
        tick(8);
        check("stable_restart", locked, 0);
        check("stable_no_pll_reset", pll_reset, 0);
        tick();
        check("glitch_relock", locked, 1);
        check("glitch_relock_pix", pix_rst, 0);

        // 6: sys_rst asserted mid-APPLY
        mode_sel = 2'd2;
        mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        tick();
        check("midapply_codes", {idsel, fbdsel, odsel}, {ID2, FB2, OD2});
        sys_rst = 1'b1;
        tick();
        check("midrst_cur_mode", cur_mode, 0);
        check("midrst_codes", {idsel, fbdsel, odsel}, {ID0, FB0, OD0});
        check("midrst_pll_reset", pll_reset, 1);
        check("midrst_busy", busy, 1);
        check("midrst_pix_rst", pix_rst, 1);
        check("midrst_locked", locked, 0);
        sys_rst = 1'b0;
        tick(11);
        check("post_rst_pending", locked, 0);
        tick();
        check("post_rst_locked", locked, 1);
        check("post_rst_mode", cur_mode, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
